// File: rtl/bank_fifo_reader.sv
// bank_fifo_reader: drains one bank of BANK_WORDS words from the ping-pong FIFO onto a valid/ready stream.
// Define BANK_FIFO_READER_ERR_EN to enable the sticky protocol error flag.
module bank_fifo_reader #(
    parameter int BANK_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        fifo_trigger,
    input  logic [15:0] fifo_data,
    input  logic        fifo_done,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    state_t      state, state_n;
    logic [7:0]  req_left, req_n, out_left, out_n;
    logic [1:0]  occ, occ_n, wr_idx;
    logic [15:0] mem [3];
    logic [15:0] mem_n [3];
    logic        pend, push, pop, last_acc, trig_n, load;

    assign out_data  = mem[0];
    assign out_valid = occ != 2'd0;
    assign out_last  = out_valid && out_left == 8'd1;

    always_comb begin
        pop      = out_valid && out_ready;
        push     = fifo_done && pend;
        last_acc = pop && out_last;
        load     = state == IDLE && start;
        occ_n    = occ + {1'b0, push} - {1'b0, pop};
        wr_idx   = occ - {1'b0, pop};
        req_n    = load ? 8'(BANK_WORDS) : req_left - {7'd0, push};
        out_n    = load ? 8'(BANK_WORDS) : out_left - {7'd0, pop};
        state_n  = state == IDLE ? (start ? READ : IDLE) :
                   last_acc ? IDLE :
                   (state == READ && req_left == 8'd0 && !pend) ? DRAIN : state;
        // a trigger in flight already owns one buffer slot and one remaining word
        trig_n   = state_n == READ && req_n > {7'd0, fifo_trigger} &&
                   {1'b0, occ_n} + {2'd0, fifo_trigger} < 3'd3;
        mem_n[0] = (push && wr_idx == 2'd0) ? fifo_data : pop ? mem[1] : mem[0];
        mem_n[1] = (push && wr_idx == 2'd1) ? fifo_data : pop ? mem[2] : mem[1];
        mem_n[2] = (push && wr_idx == 2'd2) ? fifo_data : pop ? 16'd0 : mem[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_left     <= 8'd0;
            out_left     <= 8'd0;
            occ          <= 2'd0;
            pend         <= 1'b0;
            fifo_trigger <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem          <= '{default: 16'd0};
        end else begin
            state        <= state_n;
            req_left     <= req_n;
            out_left     <= out_n;
            occ          <= occ_n;
            pend         <= fifo_trigger;
            fifo_trigger <= trig_n;
            busy         <= state_n != IDLE;
            done         <= last_acc;
            mem          <= mem_n;
        end
    end

`ifdef BANK_FIFO_READER_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if ((fifo_done && !pend) || (start && busy))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bank_fifo_reader.sv
// tb_bank_fifo_reader: randomized scoreboard bench for bank_fifo_reader (128-word and 1-word instances).
module tb_bank_fifo_reader;
    localparam int BW = 128;
`ifdef BANK_FIFO_READER_ERR_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    logic        clk = 0, rst = 1, start = 0, fifo_done = 0, out_ready = 0;
    logic [15:0] fifo_data = 0;
    logic        busy, done, fifo_trigger, out_valid, out_last, err;
    logic [15:0] out_data;

    logic        o_start = 0, o_fifo_done = 0, o_out_ready = 0;
    logic [15:0] o_fifo_data = 0;
    logic        o_busy, o_done, o_trig, o_out_valid, o_out_last, o_err;
    logic [15:0] o_out_data;

    int          chk = 0, fails = 0, cyc = 0, n_acc = 0, n_done = 0;
    int          left, max_q, trig_cnt, first_v, done_c;
    logic [15:0] q [$];
    logic [15:0] src = 0, exp_w = 0, acc_data = 0;
    logic        acc = 0, acc_last = 0, ok = 0;
    bit          grant_en = 1, rand_grant = 0, nxt_grant = 0;
    int          ready_mode = 1;

    bank_fifo_reader #(.BANK_WORDS(BW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .fifo_trigger(fifo_trigger), .fifo_data(fifo_data), .fifo_done(fifo_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .err(err)
    );

    bank_fifo_reader #(.BANK_WORDS(1)) u_one (
        .clk(clk), .rst(rst), .start(o_start), .busy(o_busy), .done(o_done),
        .fifo_trigger(o_trig), .fifo_data(o_fifo_data), .fifo_done(o_fifo_done),
        .out_data(o_out_data), .out_valid(o_out_valid), .out_ready(o_out_ready),
        .out_last(o_out_last), .err(o_err)
    );

    always #5 clk = ~clk;

    // FIFO model grants a trigger one cycle later; every granted word joins the expected queue
    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        fifo_done = nxt_grant;
        fifo_data = nxt_grant ? src : 16'($urandom);
        if (nxt_grant) begin
            q.push_back(src);
            src++;
        end
        nxt_grant = fifo_trigger && grant_en && (!rand_grant || $urandom_range(0, 2) != 0);
        out_ready = ready_mode == 1 || (ready_mode == 2 && $urandom_range(0, 3) != 0);
        acc = out_valid && out_ready;
        acc_data = out_data;
        acc_last = out_last;
    endtask

    task automatic begin_xfer(input logic [15:0] first);
        q.delete();
        n_acc = 0;
        n_done = 0;
        src = first;
        cyc = 0;
        start = 1;
        tick;
        start = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        chk++;
        if ({busy, done, fifo_trigger, out_valid, out_last, err, out_data} !== 22'd0 ||
            {o_busy, o_done, o_trig, o_out_valid, o_out_last, o_err} !== 6'd0) begin
            fails++;
            $display("FAIL reset: got %b/%h, want all zero", {busy, done, fifo_trigger, out_valid, out_last, err}, out_data);
        end
        rst = 0;
    endtask

    task automatic test_full_transfer;
        ready_mode = 1; rand_grant = 0; grant_en = 1;
        first_v = -1; done_c = -1;
        begin_xfer(16'h0000);
        chk++;
        if ({busy, fifo_trigger} !== 2'b11) begin
            fails++;
            $display("FAIL full start: busy/trigger got %b%b, want 11", busy, fifo_trigger);
        end
        for (int i = 0; i < 400; i++) begin
            if (out_valid && first_v < 0) first_v = cyc;
            if (acc) begin
                chk++;
                ok = q.size() != 0;
                if (ok) exp_w = q.pop_front();
                if (!ok || acc_data !== exp_w || acc_last !== (n_acc == BW - 1)) begin
                    fails++;
                    $display("FAIL full word %0d: got %h last=%b, want %h last=%b", n_acc, acc_data, acc_last, exp_w, n_acc == BW - 1);
                end
                n_acc++;
            end
            if (done) begin
                n_done++;
                if (done_c < 0) done_c = cyc;
                chk++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL full busy in done cycle: got %b, want 0", busy);
                end
            end
            if (done_c >= 0 && cyc >= done_c + 3) break;
            tick;
        end
        chk++;
        if (first_v != 3) begin fails++; $display("FAIL full first valid cycle: got %0d, want 3", first_v); end
        chk++;
        if (done_c != 131 || n_done != 1) begin fails++; $display("FAIL full done: cycle %0d pulses %0d, want 131 and 1", done_c, n_done); end
        chk++;
        if (n_acc != BW || q.size() != 0) begin fails++; $display("FAIL full count: got %0d words %0d left, want %0d and 0", n_acc, q.size(), BW); end
    endtask

    task automatic test_backpressure;
        ready_mode = 2; rand_grant = 1; grant_en = 1;
        left = -1; max_q = 0;
        begin_xfer(16'($urandom));
        for (int i = 0; i < 3000 && n_done == 0; i++) begin
            if (acc) begin
                chk++;
                ok = q.size() != 0;
                if (ok) exp_w = q.pop_front();
                if (!ok || acc_data !== exp_w || acc_last !== (n_acc == BW - 1)) begin
                    fails++;
                    $display("FAIL stall word %0d: got %h last=%b, want %h last=%b", n_acc, acc_data, acc_last, exp_w, n_acc == BW - 1);
                end
                n_acc++;
            end
            if (done) n_done++;
            if (q.size() > max_q) max_q = q.size();
            if (n_acc >= 30 && left < 0) begin
                left = 20; ready_mode = 0; rand_grant = 0;
            end else if (left > 0) begin
                left--;
                if (left == 0) begin
                    chk++;
                    if (q.size() != 3 || fifo_trigger !== 1'b0 || out_valid !== 1'b1) begin
                        fails++;
                        $display("FAIL stall end: buffered %0d trigger %b valid %b, want 3 0 1", q.size(), fifo_trigger, out_valid);
                    end
                    ready_mode = 2; rand_grant = 1;
                end
            end
            tick;
        end
        chk++;
        if (max_q > 3) begin fails++; $display("FAIL stall occupancy: got %0d, want <= 3", max_q); end
        chk++;
        if (n_done != 1 || n_acc != BW || q.size() != 0) begin
            fails++;
            $display("FAIL stall count: done %0d words %0d left %0d, want 1 %0d 0", n_done, n_acc, q.size(), BW);
        end
    endtask

    task automatic test_bank_not_ready;
        ready_mode = 1; rand_grant = 0; grant_en = 1;
        left = -1; trig_cnt = 0;
        begin_xfer(16'($urandom));
        for (int i = 0; i < 3000 && n_done == 0; i++) begin
            if (acc) begin
                chk++;
                ok = q.size() != 0;
                if (ok) exp_w = q.pop_front();
                if (!ok || acc_data !== exp_w || acc_last !== (n_acc == BW - 1)) begin
                    fails++;
                    $display("FAIL hold word %0d: got %h last=%b, want %h last=%b", n_acc, acc_data, acc_last, exp_w, n_acc == BW - 1);
                end
                n_acc++;
            end
            if (done) n_done++;
            if (n_acc >= 10 && left < 0) begin
                left = 50; grant_en = 0;
            end else if (left > 0) begin
                left--;
                if (fifo_trigger) trig_cnt++;
                if (left == 0) begin
                    chk++;
                    if (out_valid !== 1'b0 || fifo_trigger !== 1'b1 || q.size() != 0 || trig_cnt < 48) begin
                        fails++;
                        $display("FAIL hold end: valid %b trigger %b buffered %0d polls %0d, want 0 1 0 >=48", out_valid, fifo_trigger, q.size(), trig_cnt);
                    end
                    grant_en = 1;
                end
            end
            tick;
        end
        chk++;
        if (n_done != 1 || n_acc != BW || q.size() != 0) begin
            fails++;
            $display("FAIL hold count: done %0d words %0d left %0d, want 1 %0d 0", n_done, n_acc, q.size(), BW);
        end
    endtask

    task automatic test_reset_mid;
        ready_mode = 2; rand_grant = 1; grant_en = 1;
        begin_xfer(16'($urandom));
        for (int i = 0; i < 2000 && n_acc < 40; i++) begin
            if (acc) begin
                chk++;
                ok = q.size() != 0;
                if (ok) exp_w = q.pop_front();
                if (!ok || acc_data !== exp_w || acc_last !== 1'b0) begin
                    fails++;
                    $display("FAIL abort word %0d: got %h last=%b, want %h last=0", n_acc, acc_data, acc_last, exp_w);
                end
                n_acc++;
            end
            if (n_acc < 40) tick;
        end
        #2 rst = 1;
        #1;
        chk++;
        if (n_acc != 40 || {busy, done, fifo_trigger, out_valid, out_last, err, out_data} !== 22'd0) begin
            fails++;
            $display("FAIL async reset: words %0d outputs %b/%h, want 40 and all zero", n_acc, {busy, done, fifo_trigger, out_valid, out_last, err}, out_data);
        end
        nxt_grant = 0;
        fifo_done = 0;
        tick;
        rst = 0;
        ready_mode = 1;
        begin_xfer(16'($urandom));
        for (int i = 0; i < 400 && n_done == 0; i++) begin
            if (acc) begin
                chk++;
                ok = q.size() != 0;
                if (ok) exp_w = q.pop_front();
                if (!ok || acc_data !== exp_w || acc_last !== (n_acc == BW - 1)) begin
                    fails++;
                    $display("FAIL restart word %0d: got %h last=%b, want %h last=%b", n_acc, acc_data, acc_last, exp_w, n_acc == BW - 1);
                end
                n_acc++;
            end
            if (done) n_done++;
            tick;
        end
        chk++;
        if (n_done != 1 || n_acc != BW || q.size() != 0) begin
            fails++;
            $display("FAIL restart count: done %0d words %0d left %0d, want 1 %0d 0", n_done, n_acc, q.size(), BW);
        end
    endtask

    task automatic test_err;
        ready_mode = 1; rand_grant = 0; grant_en = 1;
        chk++;
        if (err !== 1'b0) begin fails++; $display("FAIL err before: got %b, want 0", err); end
        begin_xfer(16'($urandom));
        for (int i = 0; i < 400 && n_done == 0; i++) begin
            if (acc) begin
                chk++;
                ok = q.size() != 0;
                if (ok) exp_w = q.pop_front();
                if (!ok || acc_data !== exp_w || acc_last !== (n_acc == BW - 1)) begin
                    fails++;
                    $display("FAIL err word %0d: got %h last=%b, want %h last=%b", n_acc, acc_data, acc_last, exp_w, n_acc == BW - 1);
                end
                n_acc++;
            end
            if (done) n_done++;
            if (cyc == 7) begin
                chk++;
                if (err !== ERR_EXP) begin fails++; $display("FAIL err start while busy: got %b, want %b", err, ERR_EXP); end
            end
            start = cyc == 6;
            tick;
            start = 0;
        end
        chk++;
        if (n_done != 1 || n_acc != BW || err !== ERR_EXP) begin
            fails++;
            $display("FAIL err transfer: done %0d words %0d err %b, want 1 %0d %b", n_done, n_acc, err, BW, ERR_EXP);
        end
        #2 rst = 1;
        nxt_grant = 0;
        tick;
        rst = 0;
        chk++;
        if (err !== 1'b0) begin fails++; $display("FAIL err clear: got %b, want 0", err); end
        fifo_done = 1;
        fifo_data = 16'($urandom);
        tick;
        chk++;
        if (err !== ERR_EXP || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL err spurious: err %b valid %b busy %b, want %b 0 0", err, out_valid, busy, ERR_EXP);
        end
        repeat (3) tick;
        chk++;
        if (err !== ERR_EXP || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL err sticky: err %b valid %b, want %b 0", err, out_valid, ERR_EXP);
        end
    endtask

    task automatic test_single_word;
        logic [15:0] q1 [$];
        logic [15:0] e1;
        logic        prev = 0;
        int          dc [$];
        int          n_words = 0;
        o_out_ready = 1;
        cyc = 0;
        o_start = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            o_fifo_done = prev;
            o_fifo_data = 16'($urandom);
            if (prev) q1.push_back(o_fifo_data);
            prev = o_trig;
            o_start = o_done && dc.size() == 0;
            if (o_done) dc.push_back(cyc);
            if (cyc == 1 || cyc == 5) begin
                chk++;
                if ({o_busy, o_trig} !== 2'b11) begin fails++; $display("FAIL single start cycle %0d: busy/trigger %b%b, want 11", cyc, o_busy, o_trig); end
            end
            if (o_out_valid) begin
                chk++;
                ok = q1.size() != 0;
                e1 = ok ? q1.pop_front() : 16'd0;
                if (!ok || o_out_data !== e1 || o_out_last !== 1'b1 || !(cyc == 3 || cyc == 7)) begin
                    fails++;
                    $display("FAIL single word cycle %0d: got %h last=%b, want %h last=1 at cycle 3 or 7", cyc, o_out_data, o_out_last, e1);
                end
                n_words++;
            end
        end
        o_start = 0;
        chk++;
        if (dc.size() != 2 || n_words != 2) begin
            fails++;
            $display("FAIL single count: done pulses %0d words %0d, want 2 2", dc.size(), n_words);
        end else begin
            chk++;
            if (dc[0] != 4 || dc[1] != 8) begin fails++; $display("FAIL single done: cycles %0d %0d, want 4 8", dc[0], dc[1]); end
        end
    endtask

    initial begin
        test_reset;
        test_full_transfer;
        test_backpressure;
        test_bank_not_ready;
        test_reset_mid;
        test_err;
        test_single_word;
        $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", fails);
        $fatal(1);
    end
endmodule
